// File: rtl/uart_frame_tx.sv
// Framed 8N1 UART transmitter: START_BYTE, payload bytes, optional XOR checksum, STOP_BYTE.
// Optional checksum byte enabled by defining UART_FRAME_TX_CSUM_EN.
module uart_frame_tx #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter logic [7:0]  START_BYTE = 8'h0A,
   parameter logic [7:0]  STOP_BYTE  = 8'h08
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       TxD,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned BitCyc = CLK_FREQ / BAUD;
   localparam int unsigned CntW   = (BitCyc > 1) ? $clog2(BitCyc) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(BitCyc - 1);

`ifdef UART_FRAME_TX_CSUM_EN
   typedef enum logic [2:0] {StIdle, StHdr, StPay, StCsum, StTrl} state_e;
`else
   typedef enum logic [2:0] {StIdle, StHdr, StPay, StTrl} state_e;
`endif

   state_e state_q, state_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   last_q, last_d;
`ifdef UART_FRAME_TX_CSUM_EN
   logic [7:0] csum_q, csum_d;
`endif

   logic            tx_q;
   logic            sh_busy_q;
   logic [8:0]      shreg_q;
   logic [CntW-1:0] bit_cnt_q;
   logic [3:0]      bit_idx_q;

   logic       load;
   logic [7:0] load_byte;
   logic       accept;
   logic       bit_end, byte_end, sh_free;

   assign bit_end  = sh_busy_q && (bit_cnt_q == CntMax);
   assign byte_end = bit_end && (bit_idx_q == 4'd9);
   // A byte may be loaded on the last stop-bit cycle so the next start bit follows without a gap.
   assign sh_free  = !sh_busy_q || byte_end;
   assign accept   = in_valid && in_ready;

   // Byte shifter: bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q      <= 1'b1;
         sh_busy_q <= 1'b0;
         shreg_q   <= '1;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
      end else if (load) begin
         tx_q      <= 1'b0;
         sh_busy_q <= 1'b1;
         shreg_q   <= {1'b1, load_byte};
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
      end else if (sh_busy_q) begin
         if (bit_end) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 4'd9) begin
               sh_busy_q <= 1'b0;
               tx_q      <= 1'b1;
               bit_idx_q <= '0;
            end else begin
               tx_q      <= shreg_q[0];
               shreg_q   <= {1'b1, shreg_q[8:1]};
               bit_idx_q <= bit_idx_q + 4'd1;
            end
         end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         last_q  <= 1'b0;
`ifdef UART_FRAME_TX_CSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         last_q  <= last_d;
`ifdef UART_FRAME_TX_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      last_d    = last_q;
      load      = 1'b0;
      load_byte = START_BYTE;
      in_ready  = 1'b0;
`ifdef UART_FRAME_TX_CSUM_EN
      csum_d    = csum_q;
`endif

      unique case (state_q)
         StIdle: begin
            last_d = 1'b0;
`ifdef UART_FRAME_TX_CSUM_EN
            csum_d = 8'h00;
`endif
            if (in_valid) begin
               load      = 1'b1;
               load_byte = START_BYTE;
               busy_d    = 1'b1;
               state_d   = StHdr;
            end
         end
         StHdr: begin
            in_ready = byte_end;
            if (byte_end) state_d = StPay;
         end
         StPay: begin
            if (!last_q) begin
               in_ready = sh_free;
            end else if (byte_end) begin
               load = 1'b1;
`ifdef UART_FRAME_TX_CSUM_EN
               load_byte = csum_q;
               state_d   = StCsum;
`else
               load_byte = STOP_BYTE;
               state_d   = StTrl;
`endif
            end
         end
`ifdef UART_FRAME_TX_CSUM_EN
         StCsum: begin
            if (byte_end) begin
               load      = 1'b1;
               load_byte = STOP_BYTE;
               state_d   = StTrl;
            end
         end
`endif
         StTrl: begin
            if (byte_end) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // in_data/in_last are only looked at on an accepted handshake.
      if (accept) begin
         load      = 1'b1;
         load_byte = in_data;
         last_d    = in_last;
         state_d   = StPay;
`ifdef UART_FRAME_TX_CSUM_EN
         csum_d    = csum_q ^ in_data;
`endif
      end
   end

   assign TxD        = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: a UART RX model decodes TxD; frame timing checked in cycles.
// Bit time is shortened (1 MHz / 9600 baud, truncated to 104 cycles) to keep runs short.
module tb_uart_frame_tx;

   localparam int unsigned ClkFreq = 1_000_000;
   localparam int unsigned Baud    = 9600;
   localparam int unsigned B       = 104;

`ifdef UART_FRAME_TX_CSUM_EN
   localparam bit Csum = 1'b1;
`else
   localparam bit Csum = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready, TxD, busy, frame_done;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int unsigned cyc = 0;

   uart_frame_tx #(
      .CLK_FREQ  (ClkFreq),
      .BAUD      (Baud),
      .START_BYTE(8'h0A),
      .STOP_BYTE (8'h08)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .TxD       (TxD),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // UART RX model, sampling mid-bit; also logs start-bit falls and frame_done cycles.
   logic [7:0]  rx_q[$];
   int unsigned fall_q[$];
   int unsigned done_q[$];
   int unsigned rx_ferr = 0;
   bit          rx_act = 1'b0;
   int unsigned rx_cnt, rx_k;
   logic [7:0]  rx_sh;

   always @(negedge clk) begin
      if (rst) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (TxD === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
            fall_q.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % B == B / 2) begin
            rx_k = rx_cnt / B;
            if (rx_k == 0) begin
               if (TxD !== 1'b0) rx_ferr++;
            end else if (rx_k <= 8) begin
               rx_sh[rx_k-1] = TxD;
            end else begin
               if (TxD !== 1'b1) rx_ferr++;
               rx_q.push_back(rx_sh);
               rx_act = 1'b0;
            end
         end
      end
      if (frame_done === 1'b1) done_q.push_back(cyc);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      rx_q.delete();
      fall_q.delete();
      done_q.delete();
      rx_ferr = 0;
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
      check_eq({tag, "_nbytes"}, rx_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
         check_eq($sformatf("%s_byte%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp[i]});
      check_eq({tag, "_framing"}, rx_ferr, 0);
   endtask

   // Present one byte and hold it until accepted; afterwards drive junk to exercise holding.
   task automatic push_byte(input logic [7:0] d, input logic last);
      bit ok = 1'b0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      for (int i = 0; i < 20 * B && !ok; i++) begin
         #1;
         if (in_ready === 1'b1) ok = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 8'hFF;
      in_last  = 1'b1;
      check_eq("accept", {31'h0, ok}, 1);
   endtask

   task automatic wait_done(input int unsigned n);
      for (int i = 0; i < 80 * B && done_q.size() < n; i++) @(negedge clk);
      check_eq("done_count", done_q.size(), n);
   endtask

   task automatic idle(input int unsigned n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #(10 * 200_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0]  exp[$];
      int unsigned nb, zeros, acc;

      // 1: reset held three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_txd", {31'h0, TxD}, 1);
         check_eq("rst_busy", {31'h0, busy}, 0);
         check_eq("rst_ready", {31'h0, in_ready}, 0);
         check_eq("rst_done", {31'h0, frame_done}, 0);
      end
      rst = 1'b0;
      idle(5);
      clear_mon();

      // 2: single payload byte 0x04
      in_data  = 8'h04;
      in_last  = 1'b1;
      in_valid = 1'b1;
      #1;
      check_eq("t2_idle_ready", {31'h0, in_ready}, 0);
      @(negedge clk);
      check_eq("t2_txd_fall", {31'h0, TxD}, 0);
      check_eq("t2_busy_rise", {31'h0, busy}, 1);
      push_byte(8'h04, 1'b1);
      wait_done(1);
      check_eq("t2_busy_end", {31'h0, busy}, 0);
      exp = '{8'h0A, 8'h04};
      if (Csum) exp.push_back(8'h04);
      exp.push_back(8'h08);
      nb = exp.size();
      idle(20);
      check_bytes("t2", exp);
      check_eq("t2_done_pulses", done_q.size(), 1);
      if (fall_q.size() == nb && done_q.size() == 1) begin
         check_eq("t2_frame_len", done_q[0] - fall_q[0], 10 * B * nb);
         for (int i = 1; i < nb; i++)
            check_eq($sformatf("t2_byte_spacing%0d", i), fall_q[i] - fall_q[i-1], 10 * B);
      end else begin
         check_eq("t2_fall_count", fall_q.size(), nb);
      end
      clear_mon();

      // 3: three bytes with a 2000-cycle stall before the second
      push_byte(8'h11, 1'b0);
      zeros = 0;
      for (int i = 0; i < 2000; i++) begin
         if (i > 10 * B + 10 && TxD !== 1'b1) zeros++;
         @(negedge clk);
      end
      check_eq("t3_stall_idle", zeros, 0);
      #1;
      check_eq("t3_stall_ready", {31'h0, in_ready}, 1);
      check_eq("t3_stall_busy", {31'h0, busy}, 1);
      push_byte(8'h22, 1'b0);
      push_byte(8'h33, 1'b1);
      wait_done(1);
      idle(20);
      exp = '{8'h0A, 8'h11, 8'h22, 8'h33};
      if (Csum) exp.push_back(8'h00);
      exp.push_back(8'h08);
      check_bytes("t3", exp);
      clear_mon();

      // 4: payload 0x04, 0x05 (checksum 0x01 when enabled)
      push_byte(8'h04, 1'b0);
      push_byte(8'h05, 1'b1);
      wait_done(1);
      idle(20);
      exp = '{8'h0A, 8'h04, 8'h05};
      if (Csum) exp.push_back(8'h01);
      exp.push_back(8'h08);
      check_bytes("t4", exp);
      clear_mon();

      // 5: reset in the middle of payload bit d[3] (0x04 -> line low there)
      push_byte(8'h04, 1'b1);
      idle(4 * B + B / 2);
      check_eq("t5_mid_bit", {31'h0, TxD}, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("t5_rst_txd", {31'h0, TxD}, 1);
      check_eq("t5_rst_busy", {31'h0, busy}, 0);
      idle(2);
      rst = 1'b0;
      clear_mon();
      zeros = 0;
      for (int i = 0; i < 40 * B; i++) begin
         if (TxD !== 1'b1) zeros++;
         @(negedge clk);
      end
      check_eq("t5_no_trailer", zeros, 0);
      check_eq("t5_no_done", done_q.size(), 0);
      push_byte(8'h04, 1'b1);
      wait_done(1);
      idle(20);
      exp = '{8'h0A, 8'h04};
      if (Csum) exp.push_back(8'h04);
      exp.push_back(8'h08);
      check_bytes("t5", exp);
      clear_mon();

      // 6: in_valid held high with in_last=1 -> back-to-back frames of 0xA5
      in_data  = 8'hA5;
      in_last  = 1'b1;
      in_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 100 * B && acc < 2; i++) begin
         #1;
         if (in_ready === 1'b1) acc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_eq("t6_accepts", acc, 2);
      wait_done(2);
      idle(15 * B);
      exp = '{8'h0A, 8'hA5};
      if (Csum) exp.push_back(8'hA5);
      exp.push_back(8'h08);
      nb = exp.size();
      for (int i = 0; i < nb; i++) exp.push_back(exp[i]);
      check_bytes("t6", exp);
      check_eq("t6_no_third", done_q.size(), 2);
      if (fall_q.size() > nb && done_q.size() >= 1)
         check_eq("t6_restart_gap", fall_q[nb] - done_q[0], 1);
      else
         check_eq("t6_fall_count", fall_q.size(), 2 * nb);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
